// File: rtl/layer_seq_pkg.sv
// Shared FSM encoding and pointer-width helper for the layer sequencer.
// Combinational only; no latency and no flow control of its own.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int MIN_PTR_W = 1;

    // A count of 1 still needs a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : MIN_PTR_W;
    endfunction

endpackage

// File: rtl/layer_input_buffer.sv
// Simple dual-port vector buffer: synchronous write, registered read (block RAM style).
// Read data appears one cycle after rd_en_i; no backpressure, caller sequences addresses.
module layer_input_buffer #(
    parameter int DEPTH      = 784,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/layer_sequencer.sv
// Buffers one input vector, replays it gap-free to a neuron layer, then serialises results.
// Latency: first neuron beat 2 cycles after last load accept; in_ready low outside LOAD,
// out_data held while out_ready is low. Optional WAIT watchdog: LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_INPUTS     = 784,
    parameter int NUM_NEURONS    = 30,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             neuron_in,
    output logic                              neuron_in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_out_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int IW = ptr_w(NUM_INPUTS);
    localparam int NW = ptr_w(NUM_NEURONS);
    localparam logic [IW-1:0] IN_LAST  = IW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0] NEU_LAST = NW'(NUM_NEURONS - 1);

    state_t                                 state_q;
    logic [IW-1:0]                          wr_ptr_q, rd_ptr_q;
    logic                                   rd_done_q, rd_vld_q;
    logic [NW-1:0]                          idx_q;
    logic [NUM_NEURONS-1:0]                 done_q, done_d;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0]                  neuron_in_q, out_data_q, rd_data;
    logic                                   neuron_in_valid_q, out_valid_q;
    logic                                   in_acc, rd_en, all_done, timeout_fire;

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != LOAD);
    assign in_acc   = in_valid && (state_q == LOAD);
    assign rd_en    = (state_q == STREAM) && !rd_done_q;

    layer_input_buffer #(
        .DEPTH     (NUM_INPUTS),
        .DATA_WIDTH(DATA_WIDTH),
        .AW        (IW)
    ) u_buf (
        .clk      (clk),
        .wr_en_i  (in_acc),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(in_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data)
    );

    always_comb begin
        done_d = done_q;
        if (state_q == WAIT) done_d = done_q | neuron_out_valid;
    end

    assign all_done = &done_d;

    always_comb begin
        result_d = result_q;
        for (int j = 0; j < NUM_NEURONS; j++) begin
            if (state_q == WAIT && neuron_out_valid[j])
                result_d[j] = neuron_out[j*DATA_WIDTH +: DATA_WIDTH];
            // Neurons that never answered drain as zero after a watchdog expiry.
            if (timeout_fire && !done_d[j])
                result_d[j] = '0;
        end
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_err_q;

    assign timeout_fire = (state_q == WAIT) && !all_done &&
                          (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err  = tmo_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == WAIT) ? tmo_cnt_q + 1'b1 : '0;
            if (timeout_fire) tmo_err_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo   = (TIMEOUT_CYCLES == 0);
    assign timeout_fire = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= LOAD;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            rd_done_q         <= 1'b0;
            rd_vld_q          <= 1'b0;
            idx_q             <= '0;
            done_q            <= '0;
            result_q          <= '0;
            neuron_in_q       <= '0;
            neuron_in_valid_q <= 1'b0;
            out_data_q        <= '0;
            out_valid_q       <= 1'b0;
        end else begin
            rd_vld_q          <= rd_en;
            neuron_in_valid_q <= rd_vld_q;
            if (rd_vld_q) neuron_in_q <= rd_data;
            done_q   <= done_d;
            result_q <= result_d;
            case (state_q)
                LOAD: if (in_acc) begin
                    if (wr_ptr_q == IN_LAST) begin
                        wr_ptr_q <= '0;
                        state_q  <= STREAM;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        if (rd_ptr_q == IN_LAST) begin
                            rd_ptr_q  <= '0;
                            rd_done_q <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end else if (!rd_vld_q && neuron_in_valid_q) begin
                        // Last beat is on the neuron bus now; WAIT starts right after it.
                        rd_done_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: if (all_done || timeout_fire) begin
                    state_q     <= DRAIN;
                    out_valid_q <= 1'b1;
                    out_data_q  <= result_d[0];
                end
                DRAIN: if (out_ready) begin
                    if (idx_q == NEU_LAST) begin
                        idx_q       <= '0;
                        done_q      <= '0;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        state_q     <= LOAD;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        out_data_q <= result_q[idx_q + 1'b1];
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign neuron_in       = neuron_in_q;
    assign neuron_in_valid = neuron_in_valid_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer with a 4-input, 2-neuron layer.
module tb_layer_sequencer;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     neuron_in;
    logic              neuron_in_valid;
    logic [NN*DW-1:0]  neuron_out;
    logic [NN-1:0]     neuron_out_valid;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_INPUTS    (NI),
        .NUM_NEURONS   (NN),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .neuron_in       (neuron_in),
        .neuron_in_valid (neuron_in_valid),
        .neuron_out      (neuron_out),
        .neuron_out_valid(neuron_out_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] exp_in[$];
    logic [DW-1:0] exp_out[$];

    typedef struct {
        logic [NI-1:0][DW-1:0] vec;
        int                    gap;
        logic [DW-1:0]         r0, r1;
        int                    stagger;
        int                    stall;
        bit                    junk;
        logic [DW-1:0]         exp0, exp1;
    } row_t;

    row_t rows[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NI-1:0][DW-1:0] mk(input logic [DW-1:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Scoreboard: stream beats and drained results are compared in order of arrival.
    always @(negedge clk) begin
        if (rst_n) begin
            if (neuron_in_valid) begin
                if (exp_in.size() == 0) check("neuron_in_unexpected", 1, 0);
                else check("neuron_in", neuron_in, exp_in.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) check("out_data_unexpected", 1, 0);
                else check("out_data", out_data, exp_out.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic load_vec(input logic [NI-1:0][DW-1:0] v, input int gap);
        for (int i = 0; i < NI; i++) begin
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = v[i];
            exp_in.push_back(v[i]);
            tick();
            in_valid = 1'b0;
            in_data  = 16'hBEEF;
            if (i < NI - 1) for (int g = 0; g < gap; g++) tick();
        end
        check("in_ready_drop", in_ready, 0);
        check("busy_stream", busy, 1);
    endtask

    task automatic stream_phase(input bit junk);
        check("nin_valid_lat1", neuron_in_valid, 0);
        tick();
        check("nin_valid_lat2", neuron_in_valid, 0);
        if (junk) begin
            neuron_out_valid = '1;
            neuron_out       = {16'hDEAD, 16'hDEAD};
        end
        tick();
        neuron_out_valid = '0;
        for (int i = 0; i < NI; i++) begin
            check("nin_valid_burst", neuron_in_valid, 1);
            tick();
        end
        check("wait_entry_nin", neuron_in_valid, 0);
        check("wait_entry_ovalid", out_valid, 0);
    endtask

    task automatic result_phase(input row_t r);
        tick();
        check("wait_idle_ovalid", out_valid, 0);
        if (r.stagger == 0) begin
            neuron_out       = {r.r1, r.r0};
            neuron_out_valid = 2'b11;
            exp_out.push_back(r.exp0);
            exp_out.push_back(r.exp1);
            out_ready = (r.stall == 0);
            tick();
        end else begin
            neuron_out       = {16'h5555, r.r0};
            neuron_out_valid = 2'b01;
            exp_out.push_back(r.exp0);
            tick();
            neuron_out_valid = 2'b00;
            for (int k = 0; k < r.stagger - 1; k++) begin
                check("stagger_hold", out_valid, 0);
                tick();
            end
            check("stagger_hold", out_valid, 0);
            neuron_out       = {r.r1, 16'h5555};
            neuron_out_valid = 2'b10;
            exp_out.push_back(r.exp1);
            out_ready = (r.stall == 0);
            tick();
        end
        neuron_out_valid = 2'b00;
        neuron_out       = {16'h3C3C, 16'h3C3C};
        check("out_valid_rise", out_valid, 1);
        for (int k = 0; k < r.stall; k++) begin
            check("bp_data", out_data, r.exp0);
            check("bp_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("busy_fall", busy, 0);
        check("in_ready_back", in_ready, 1);
        check("out_valid_fall", out_valid, 0);
        check("drain_complete", exp_out.size(), 0);
    endtask

    task automatic run_row(input row_t r);
        load_vec(r.vec, r.gap);
        stream_phase(r.junk);
        result_phase(r);
    endtask

    initial begin
        rows[0] = '{vec: mk(16'd1, 16'd2, 16'd3, 16'd4), gap: 2, r0: 16'h0100, r1: 16'hFF00,
                    stagger: 0, stall: 0, junk: 1'b0, exp0: 16'h0100, exp1: 16'hFF00};
        rows[1] = '{vec: mk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000), gap: 0, r0: 16'h1234, r1: 16'h8001,
                    stagger: 3, stall: 0, junk: 1'b1, exp0: 16'h1234, exp1: 16'h8001};
        rows[2] = '{vec: mk(16'd5, 16'd6, 16'd7, 16'd8), gap: 1, r0: 16'hABCD, r1: 16'h0001,
                    stagger: 0, stall: 5, junk: 1'b0, exp0: 16'hABCD, exp1: 16'h0001};
        rows[3] = '{vec: mk(16'h00AA, 16'h0055, 16'h0F0F, 16'hF0F0), gap: 3, r0: 16'h7FFF, r1: 16'h8000,
                    stagger: 1, stall: 2, junk: 1'b1, exp0: 16'h7FFF, exp1: 16'h8000};

        rst_n            = 1'b0;
        in_data          = '0;
        in_valid         = 1'b0;
        neuron_out       = '0;
        neuron_out_valid = '0;
        out_ready        = 1'b1;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_nin_valid", neuron_in_valid, 0);
        check("rst_neuron_in", neuron_in, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_row(rows[i]);

        // Reset while the vector is being streamed out.
        load_vec(mk(16'd9, 16'd10, 16'd11, 16'd12), 0);
        tick();
        tick();
        tick();
        tick();
        check("mid_stream_nin_valid", neuron_in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_stream_nin_valid", neuron_in_valid, 0);
        check("rst_stream_in_ready", in_ready, 1);
        check("rst_stream_busy", busy, 0);
        exp_in.delete();
        exp_out.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_row(rows[0]);

`ifdef LAYER_SEQ_TIMEOUT_EN
        load_vec(mk(16'd1, 16'd1, 16'd1, 16'd1), 0);
        stream_phase(1'b0);
        tick();
        neuron_out       = {16'h7777, 16'h0042};
        neuron_out_valid = 2'b01;
        exp_out.push_back(16'h0042);
        exp_out.push_back(16'h0000);
        tick();
        neuron_out_valid = 2'b00;
        for (int k = 0; k < 5; k++) tick();
        check("tmo_before", timeout_err, 0);
        check("tmo_before_ovalid", out_valid, 0);
        tick();
        check("tmo_set", timeout_err, 1);
        check("tmo_ovalid", out_valid, 1);
        check("tmo_data0", out_data, 16'h0042);
        tick();
        tick();
        check("tmo_busy_fall", busy, 0);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_drain_complete", exp_out.size(), 0);
`else
        check("timeout_tied_low", timeout_err, 0);
`endif

        check("stream_complete", exp_in.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
